// File: rtl/rtc_segment_encoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rtc_segment_encoder_if : stopwatch digit bus into the segment encoder |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface rtc_segment_encoder_if;
  logic [23:0] i_bcd;
  logic        i_valid;
  logic        i_lap;
  logic        i_lz_blank;
  logic        i_blink_en;
  logic [7:0]  o_segout1;
  logic [7:0]  o_segout2;
  logic [7:0]  o_segout3;
  logic [7:0]  o_segout4;
  logic [7:0]  o_segout5;
  logic [7:0]  o_segout6;
  logic        o_hold;

  modport master (
    output i_bcd, i_valid, i_lap, i_lz_blank, i_blink_en,
    input  o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6, o_hold
  );

  modport slave (
    input  i_bcd, i_valid, i_lap, i_lz_blank, i_blink_en,
    output o_segout1, o_segout2, o_segout3, o_segout4, o_segout5, o_segout6, o_hold
  );
endinterface
`default_nettype wire

// File: rtl/rtc_segment_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rtc_segment_encoder : BCD time digits to six active-low 7-seg codes   |
// | Optional macro RTC_ENC_HEX_EN: A..F shown as hex glyphs, else dash.   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module rtc_segment_encoder #(
  parameter int unsigned BLINK_DIV = 50_000_000,
  parameter logic [5:0]  DP_MASK   = 6'b010100
) (
  input  wire logic            i_sclk,
  input  wire logic            i_reset_n,
  rtc_segment_encoder_if.slave bus
);

  localparam logic [0:0]  c_LIVE       = 1'b0;
  localparam logic [0:0]  c_HOLD       = 1'b1;
  localparam logic [31:0] c_BLINK_LAST = 32'(BLINK_DIV - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_hold;
  logic             w_disp_load;
  logic [23:0]      r_cap;
  logic [23:0]      r_disp;
  logic [31:0]      r_blink_cnt;
  logic             r_blink_off;
  logic             w_blank_all;
  logic [5:0][7:0]  w_seg;
  logic [5:0][7:0]  r_seg;
  logic             w_lead;
  logic [3:0]       w_nib;
  logic [7:0]       w_code;

  function automatic logic [7:0] f_encode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
`ifdef RTC_ENC_HEX_EN
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
`else
      default: code = 8'hBF;
`endif
    endcase
    return code;
  endfunction

  // Hold FSM: state register / next-state / outputs
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= c_LIVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_LIVE:  if (bus.i_lap) w_state_next = c_HOLD;
      c_HOLD:  if (bus.i_lap) w_state_next = c_LIVE;
      default: w_state_next = c_LIVE;
    endcase
  end

  // Live display follows the capture path; a lap pulse out of HOLD reloads it.
  always_comb begin
    w_hold      = (r_state == c_HOLD);
    w_disp_load = (r_state == c_LIVE) || bus.i_lap;
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cap  <= 24'h000000;
      r_disp <= 24'h000000;
    end else begin
      if (bus.i_valid) begin
        r_cap <= bus.i_bcd;
      end
      if (w_disp_load) begin
        r_disp <= bus.i_valid ? bus.i_bcd : r_cap;
      end
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_blink_cnt <= 32'd0;
      r_blink_off <= 1'b0;
    end else if (!bus.i_blink_en) begin
      r_blink_cnt <= 32'd0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt <= 32'd0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  // Gating by the live enable lets a deasserted blink show digits on the next edge.
  assign w_blank_all = r_blink_off && bus.i_blink_en;

  always_comb begin
    w_seg  = '1;
    w_lead = 1'b1;
    w_nib  = 4'h0;
    w_code = 8'hFF;
    for (int k = 5; k >= 0; k--) begin
      w_nib  = r_disp[4*k +: 4];
      w_lead = w_lead && (w_nib == 4'h0);
      if (bus.i_lz_blank && w_lead && (k != 0)) begin
        w_code = 8'hFF;
      end else begin
        w_code = f_encode(w_nib);
      end
      if (DP_MASK[k]) begin
        w_code[7] = 1'b0;
      end
      if (w_blank_all) begin
        w_code = 8'hFF;
      end
      w_seg[k] = w_code;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_seg <= '1;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign bus.o_segout1 = r_seg[0];
  assign bus.o_segout2 = r_seg[1];
  assign bus.o_segout3 = r_seg[2];
  assign bus.o_segout4 = r_seg[3];
  assign bus.o_segout5 = r_seg[4];
  assign bus.o_segout6 = r_seg[5];
  assign bus.o_hold    = w_hold;

endmodule
`default_nettype wire

// File: tb/tb_rtc_segment_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rtc_segment_encoder : randomized bench with behavioural model      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_rtc_segment_encoder;

  localparam int unsigned c_DIV = 4;
  localparam logic [5:0]  c_DP  = 6'b010100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  rtc_segment_encoder_if bus ();

  rtc_segment_encoder #(
    .BLINK_DIV (c_DIV),
    .DP_MASK   (c_DP)
  ) dut (
    .i_sclk    (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model state
  logic [23:0] m_cap;
  logic [23:0] m_disp;
  logic        m_hold;
  int          m_cnt;
  logic        m_off;
  logic [47:0] m_seg;

  function automatic logic [7:0] ref_glyph(input logic [3:0] d);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
`ifdef RTC_ENC_HEX_EN
    tbl[10] = 8'h88; tbl[11] = 8'h83; tbl[12] = 8'hC6;
    tbl[13] = 8'hA1; tbl[14] = 8'h86; tbl[15] = 8'h8E;
`endif
    return tbl[d];
  endfunction

  // Packed result is {seg6, seg5, ..., seg1}
  function automatic logic [47:0] ref_display(input logic [23:0] disp, input logic lz, input logic off);
    logic [47:0] r;
    logic [7:0]  g;
    r = '1;
    for (int k = 0; k < 6; k++) begin
      if (lz && k > 0 && (disp >> (4 * k)) == 24'd0) g = 8'hFF;
      else g = ref_glyph(4'((disp >> (4 * k)) & 24'hF));
      if (c_DP[k]) g = g & 8'h7F;
      if (off) g = 8'hFF;
      r[8*k +: 8] = g;
    end
    return r;
  endfunction

  function automatic logic [47:0] dut_segs();
    return {bus.o_segout6, bus.o_segout5, bus.o_segout4,
            bus.o_segout3, bus.o_segout2, bus.o_segout1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cap  = '0;
    m_disp = '0;
    m_hold = 1'b0;
    m_cnt  = 0;
    m_off  = 1'b0;
    m_seg  = '1;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
  task automatic step(input logic [23:0] bcd, input logic v, input logic lap,
                      input logic lz, input logic blink);
    bus.i_bcd      = bcd;
    bus.i_valid    = v;
    bus.i_lap      = lap;
    bus.i_lz_blank = lz;
    bus.i_blink_en = blink;
    @(posedge clk);
    m_seg = ref_display(m_disp, lz, m_off && blink);
    if (!m_hold || lap) m_disp = v ? bcd : m_cap;
    if (v) m_cap = bcd;
    if (lap) m_hold = ~m_hold;
    if (!blink) begin
      m_cnt = 0;
      m_off = 1'b0;
    end else if (m_cnt == c_DIV - 1) begin
      m_cnt = 0;
      m_off = ~m_off;
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    check("segs", 64'(dut_segs()), 64'(m_seg));
    check("hold", 64'(bus.o_hold), 64'(m_hold));
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_segs"}, 64'(dut_segs()), 64'hFFFF_FFFF_FFFF);
    check({tag, "_hold"}, 64'(bus.o_hold), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.i_bcd = '0; bus.i_valid = 0; bus.i_lap = 0; bus.i_lz_blank = 0; bus.i_blink_en = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_segs", 64'(dut_segs()), 64'hFFFF_FFFF_FFFF);
    check("rst_hold", 64'(bus.o_hold), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_segs", 64'(dut_segs()), 64'hFFFF_FFFF_FFFF);
    @(negedge clk);

    step(24'h000000, 1, 0, 0, 0);
    step(24'h000000, 0, 0, 0, 0);
    check("zero_nolz", 64'(dut_segs()), 64'hC0_40_C0_40_C0_C0);

    step(24'h012345, 1, 0, 1, 0);
    step(24'h000000, 0, 0, 1, 0);
    check("lz_012345", 64'(dut_segs()), 64'hFF_79_A4_30_99_92);
    step(24'h000000, 1, 0, 1, 0);
    step(24'h000000, 0, 0, 1, 0);
    check("lz_zero", 64'(dut_segs()), 64'hFF_7F_FF_7F_FF_C0);

    step(24'h000100, 1, 0, 0, 0);
    step(24'h000101, 1, 1, 0, 0);
    step(24'h000000, 0, 0, 0, 0);
    check("hold_frz", 64'(dut_segs()), 64'hC0_40_C0_79_C0_F9);
    step(24'h000500, 1, 0, 0, 0);
    step(24'h000000, 0, 0, 0, 0);
    check("hold_keep", 64'(dut_segs()), 64'hC0_40_C0_79_C0_F9);
    step(24'h000000, 0, 1, 0, 0);
    step(24'h000000, 0, 0, 0, 0);
    check("unhold_s3", 64'(bus.o_segout3), 64'h12);

    step(24'h00000C, 1, 0, 0, 0);
    step(24'h000000, 0, 0, 0, 0);
`ifdef RTC_ENC_HEX_EN
    check("hex_c", 64'(bus.o_segout1), 64'hC6);
`else
    check("hex_c", 64'(bus.o_segout1), 64'hBF);
`endif

    step(24'h123456, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(24'h0, 0, 0, 0, 1);
    for (int i = 0; i < 12 && !m_off; i++) step(24'h0, 0, 0, 0, 1);
    step(24'h0, 0, 0, 0, 1);
    step(24'h0, 0, 0, 0, 0);
    check("blink_rel", 64'(dut_segs()), 64'(ref_display(24'h123456, 1'b0, 1'b0)));

    for (int i = 0; i < 400; i++) begin
      logic [23:0] b;
      b = 24'($urandom);
      if ($urandom_range(0, 2) == 0) b = b & 24'h000F0F;
      step(b, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 9) != 0) && (i % 80 > 20));
    end

    step(24'h004321, 1, 1, 0, 1);
    step(24'h0, 0, 0, 0, 1);
    async_reset("arst_hold");
    step(24'h0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) step(24'h000777, 1, 0, 0, 1);
    async_reset("arst_blink");
    step(24'h0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(24'($urandom), 1, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
